// File: rtl/rf_sb_mp_pkg.sv
// Shared definitions for the scoreboarded multi-port register file.
// The load-mode codes are the ctrl_encode_def set used by the control unit
// and the data-memory path, so they must not be renumbered here.
package rf_sb_mp_pkg;

  // Load-mode codes driven on wb_mode. Any other code behaves as a word load.
  localparam logic [2:0] RF_LW  = 3'b000;
  localparam logic [2:0] RF_LH  = 3'b001;
  localparam logic [2:0] RF_LHU = 3'b010;
  localparam logic [2:0] RF_LB  = 3'b011;
  localparam logic [2:0] RF_LBU = 3'b100;

  // Width of the load datapath; load extension is defined for 32-bit words only.
  localparam int unsigned LD_W = 32;

endpackage

// File: rtl/rf_load_ext.sv
// Load alignment/extension: selects the halfword or byte addressed by the
// low address bits, sign- or zero-extends it, and flags misaligned accesses.
// Purely combinational so the memory stage and store path can reuse it.
module rf_load_ext
  import rf_sb_mp_pkg::*;
(
  input  logic [LD_W-1:0] raw,
  input  logic [2:0]      mode,
  input  logic [1:0]      memaddr,
  output logic [LD_W-1:0] ext,
  output logic            misalign
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Pick the addressed halfword (bit 0 of the offset is ignored) and byte.
  always_comb begin
    half_sel = memaddr[1] ? raw[31:16] : raw[15:0];
    case (memaddr)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
  end

  // Extend according to mode; unknown codes fall back to a word load.
  always_comb begin
    ext      = raw;
    misalign = (memaddr != 2'd0);
    case (mode)
      RF_LH: begin
        ext      = {{16{half_sel[15]}}, half_sel};
        misalign = memaddr[0];
      end
      RF_LHU: begin
        ext      = {16'h0000, half_sel};
        misalign = memaddr[0];
      end
      RF_LB: begin
        ext      = {{24{byte_sel[7]}}, byte_sel};
        misalign = 1'b0;
      end
      RF_LBU: begin
        ext      = {24'h000000, byte_sel};
        misalign = 1'b0;
      end
      default: begin
        ext      = raw;
        misalign = (memaddr != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/rf_sb_mp.sv
// Multi-port register file with ALU and load write ports, optional
// same-cycle write-to-read bypass and a per-register busy scoreboard that
// hazard logic uses for stall decisions. Register 0 is hard zero, never busy.
module rf_sb_mp
  import rf_sb_mp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wa_en,
  input  logic [ADDR_W-1:0]     wa_addr,
  input  logic [DATA_W-1:0]     wa_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_W-1:0]     wb_raw,
  input  logic [2:0]            wb_mode,
  input  logic [1:0]            wb_memaddr,
  input  logic                  iss_vld,
  input  logic [ADDR_W-1:0]     iss_rd,
  output logic [ADDR_W:0]       busy_cnt,
  output logic                  wr_coll,
  output logic                  ld_misalign,
  input  logic [ADDR_W-1:0]     reg_sel,
  output logic [DATA_W-1:0]     reg_data
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam int unsigned CW   = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [NREG-1:0]   clr_vec, set_vec;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_coll_q, ld_mis_q;

  logic [DATA_W-1:0] wb_ext;
  logic              wb_mis;
  logic              wa_hit, wb_hit, iss_hit, coll;
  logic              rise, fall_a, fall_b;

  rf_load_ext u_load_ext (
    .raw      (wb_raw),
    .mode     (wb_mode),
    .memaddr  (wb_memaddr),
    .ext      (wb_ext),
    .misalign (wb_mis)
  );

  // Qualified write/issue strobes; everything presented during reset is dropped,
  // which also keeps the bypass paths quiet so outputs read zero under reset.
  always_comb begin
    wa_hit  = !rst && wa_en && (wa_addr != '0);
    wb_hit  = !rst && wb_en && (wb_addr != '0);
    iss_hit = !rst && iss_vld && (iss_rd != '0);
    coll    = wa_hit && wb_hit && (wa_addr == wb_addr);
  end

  // Scoreboard next state: writebacks clear, issue sets, set wins on overlap.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wa_hit) clr_vec[wa_addr] = 1'b1;
    if (wb_hit) clr_vec[wb_addr] = 1'b1;
    if (iss_hit) set_vec[iss_rd] = 1'b1;
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  // Incremental busy count: at most one rise (issue) and two falls (writebacks).
  // A collision is counted once, and a fall is cancelled by a same-address issue.
  always_comb begin
    rise   = iss_hit && !busy_q[iss_rd];
    fall_a = wa_hit && busy_q[wa_addr] && !(iss_hit && (iss_rd == wa_addr));
    fall_b = wb_hit && busy_q[wb_addr] && !(iss_hit && (iss_rd == wb_addr)) && !coll;
    cnt_d  = cnt_q + CW'(rise) - CW'(fall_a) - CW'(fall_b);
  end

  // Register storage; port A takes priority when both ports hit one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (wa_hit && (wa_addr == ADDR_W'(i))) begin
          mem_q[i] <= wa_data;
        end else if (wb_hit && (wb_addr == ADDR_W'(i))) begin
          mem_q[i] <= wb_ext;
        end
      end
    end
  end

  // Scoreboard, counter and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      cnt_q     <= '0;
      wr_coll_q <= 1'b0;
      ld_mis_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      wr_coll_q <= coll;
      ld_mis_q  <= wb_en && wb_mis;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

    // Read mux: zero register, then bypass (A before B), then storage.
    always_comb begin
      data = mem_q[addr];
      busy = busy_q[addr];
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end else if (BYPASS != 0) begin
        if (wa_hit && (wa_addr == addr)) begin
          data = wa_data;
        end else if (wb_hit && (wb_addr == addr)) begin
          data = wb_ext;
        end
        busy = busy_q[addr] && !clr_vec[addr];
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = data;
    assign rd_busy[g]                  = busy;
  end

  assign busy_cnt    = cnt_q;
  assign wr_coll     = wr_coll_q;
  assign ld_misalign = ld_mis_q;
  assign reg_data    = (reg_sel == '0) ? '0 : mem_q[reg_sel];

endmodule

// File: tb/tb_rf_sb_mp.sv
// Self-checking bench for rf_sb_mp: directed steps followed by randomized
// traffic, all compared against a behavioural register-file/scoreboard model.
module tb_rf_sb_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_raw;
  logic [2:0]  wb_mode;
  logic [1:0]  wb_memaddr;
  logic        iss_vld;
  logic [4:0]  iss_rd;
  logic [5:0]  busy_cnt;
  logic        wr_coll;
  logic        ld_misalign;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;

  rf_sb_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wa_en       (wa_en),
    .wa_addr     (wa_addr),
    .wa_data     (wa_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_raw      (wb_raw),
    .wb_mode     (wb_mode),
    .wb_memaddr  (wb_memaddr),
    .iss_vld     (iss_vld),
    .iss_rd      (iss_rd),
    .busy_cnt    (busy_cnt),
    .wr_coll     (wr_coll),
    .ld_misalign (ld_misalign),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  logic        exp_coll;
  logic        exp_mis;

  logic [2:0]  ld_mode_t [6] = '{3'd3, 3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
  logic [1:0]  ld_off_t  [6] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd2};
  logic [31:0] ld_exp_t  [6] = '{32'h00000001, 32'hFFFFFF80, 32'h0000007F,
                                 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Load extension from the mode table: 1 LH, 2 LHU, 3 LB, 4 LBU, else LW.
  function automatic logic [31:0] f_ext(logic [31:0] raw, logic [2:0] mode, logic [1:0] off);
    logic [15:0] h;
    logic [7:0]  b;
    h = 16'(raw >> (16 * int'(off[1])));
    b = 8'(raw >> (8 * int'(off)));
    case (mode)
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0000, h};
      3'd3:    return {{24{b[7]}}, b};
      3'd4:    return {24'h000000, b};
      default: return raw;
    endcase
  endfunction

  function automatic logic f_mis(logic [2:0] mode, logic [1:0] off);
    if (mode == 3'd1 || mode == 3'd2) return off[0];
    if (mode == 3'd3 || mode == 3'd4) return 1'b0;
    return off != 2'd0;
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!rst && wa_en && wa_addr == a) return wa_data;
    if (!rst && wb_en && wb_addr == a) return f_ext(wb_raw, wb_mode, wb_memaddr);
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(logic [4:0] a);
    logic written;
    written = !rst && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a));
    return (a != 5'd0) && m_busy[a] && !written;
  endfunction

  function automatic int popcount();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    exp_coll = 1'b0;
    exp_mis  = 1'b0;
  endtask

  task automatic idle();
    rd_addr    = '0;
    wa_en      = 1'b0;
    wa_addr    = '0;
    wa_data    = '0;
    wb_en      = 1'b0;
    wb_addr    = '0;
    wb_raw     = '0;
    wb_mode    = '0;
    wb_memaddr = '0;
    iss_vld    = 1'b0;
    iss_rd     = '0;
    reg_sel    = '0;
  endtask

  // Move from just after a rising edge to the falling edge.
  task automatic settle();
    #4;
  endtask

  task automatic comb_check();
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a;
      a = rd_addr[p*5 +: 5];
      chk("rd_data", rd_data[p*32 +: 32], exp_rd(a));
      chk("rd_busy", 32'(rd_busy[p]), 32'(exp_busy(a)));
    end
  endtask

  // Advance the model across the rising edge, then check registered state.
  task automatic edge_step();
    logic        wa_ok, wb_ok;
    logic [31:0] ext;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      wa_ok    = wa_en && wa_addr != 5'd0;
      wb_ok    = wb_en && wb_addr != 5'd0;
      ext      = f_ext(wb_raw, wb_mode, wb_memaddr);
      exp_coll = wa_ok && wb_ok && wa_addr == wb_addr;
      exp_mis  = wb_en && f_mis(wb_mode, wb_memaddr);
      if (wb_ok) m_mem[wb_addr] = ext;
      if (wa_ok) m_mem[wa_addr] = wa_data;
      if (wa_ok) m_busy[wa_addr] = 1'b0;
      if (wb_ok) m_busy[wb_addr] = 1'b0;
      if (iss_vld && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
    #1;
    chk("busy_cnt", 32'(busy_cnt), 32'(popcount()));
    chk("wr_coll", 32'(wr_coll), 32'(exp_coll));
    chk("ld_misalign", 32'(ld_misalign), 32'(exp_mis));
    chk("reg_data", reg_data, (reg_sel == 5'd0) ? 32'h0 : m_mem[reg_sel]);
  endtask

  task automatic go();
    settle();
    comb_check();
    edge_step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    chk("rst_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("rst_wr_coll", 32'(wr_coll), 32'd0);
    chk("rst_ld_mis", 32'(ld_misalign), 32'd0);

    // Port A write to r5, read through bypass then storage; r0 stays zero.
    idle();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h12345678; rd_addr = {5'd5, 5'd5};
    settle();
    chk("bypass_p0", rd_data[31:0], 32'h12345678);
    chk("bypass_p1", rd_data[63:32], 32'h12345678);
    comb_check();
    edge_step();
    idle();
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFFFFFF; rd_addr = {5'd5, 5'd0};
    settle();
    chk("stored_r5", rd_data[63:32], 32'h12345678);
    chk("r0_bypass", rd_data[31:0], 32'h0);
    comb_check();
    edge_step();
    idle();
    settle();
    chk("r0_stored", rd_data[31:0], 32'h0);
    comb_check();
    edge_step();

    // Load extension on port B into r10.
    for (int k = 0; k < 6; k++) begin
      idle();
      wb_en = 1'b1; wb_addr = 5'd10; wb_raw = 32'h80FF7F01;
      wb_mode = ld_mode_t[k]; wb_memaddr = ld_off_t[k]; rd_addr = {5'd0, 5'd10};
      settle();
      chk("ld_ext", rd_data[31:0], ld_exp_t[k]);
      comb_check();
      edge_step();
    end
    chk("lw_misalign_pulse", 32'(ld_misalign), 32'd1);
    idle();
    reg_sel = 5'd10;
    go();
    chk("lw_written", reg_data, 32'h80FF7F01);
    chk("misalign_cleared", 32'(ld_misalign), 32'd0);

    // Scoreboard set/clear.
    idle(); iss_vld = 1'b1; iss_rd = 5'd7; go();
    idle(); iss_vld = 1'b1; iss_rd = 5'd9; go();
    idle(); rd_addr = {5'd0, 5'd7};
    settle();
    chk("busy_cnt_2", 32'(busy_cnt), 32'd2);
    chk("rd_busy_r7", 32'(rd_busy[0]), 32'd1);
    comb_check();
    edge_step();
    idle();
    wb_en = 1'b1; wb_addr = 5'd7; wb_raw = 32'h0000ABCD; rd_addr = {5'd0, 5'd7};
    settle();
    chk("rd_busy_r7_clr", 32'(rd_busy[0]), 32'd0);
    comb_check();
    edge_step();
    chk("busy_cnt_1", 32'(busy_cnt), 32'd1);
    idle();
    iss_vld = 1'b1; iss_rd = 5'd3; wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h33;
    go();
    idle(); rd_addr = {5'd0, 5'd3};
    settle();
    chk("set_wins_r3", 32'(rd_busy[0]), 32'd1);
    chk("busy_cnt_set_wins", 32'(busy_cnt), 32'd2);
    comb_check();
    edge_step();

    // Write collision, then independent dual writes.
    idle();
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h11;
    wb_en = 1'b1; wb_addr = 5'd4; wb_raw = 32'h22; reg_sel = 5'd4;
    go();
    chk("coll_pulse", 32'(wr_coll), 32'd1);
    chk("coll_a_wins", reg_data, 32'h11);
    idle();
    go();
    chk("coll_one_cycle", 32'(wr_coll), 32'd0);
    wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'hA1;
    wb_en = 1'b1; wb_addr = 5'd2; wb_raw = 32'hB2;
    go();
    idle(); rd_addr = {5'd2, 5'd1};
    settle();
    chk("dual_r1", rd_data[31:0], 32'hA1);
    chk("dual_r2", rd_data[63:32], 32'hB2);
    comb_check();
    edge_step();

    // Mid-stream asynchronous reset with five busy registers and pending work.
    for (int r = 11; r < 14; r++) begin
      idle(); iss_vld = 1'b1; iss_rd = 5'(r); go();
    end
    chk("five_busy", 32'(busy_cnt), 32'd5);
    idle();
    wa_en = 1'b1; wa_addr = 5'd20; wa_data = 32'h1;
    wb_en = 1'b1; wb_addr = 5'd20; wb_raw = 32'h2;
    go();
    idle();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD;
    wb_en = 1'b1; wb_addr = 5'd6; wb_raw = 32'hBEEF; wb_memaddr = 2'd1;
    iss_vld = 1'b1; iss_rd = 5'd14; rd_addr = {5'd5, 5'd11}; reg_sel = 5'd5;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd0", rd_data[31:0], 32'h0);
    chk("arst_rd1", rd_data[63:32], 32'h0);
    chk("arst_rd_busy", 32'(rd_busy), 32'd0);
    chk("arst_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("arst_wr_coll", 32'(wr_coll), 32'd0);
    chk("arst_ld_mis", 32'(ld_misalign), 32'd0);
    chk("arst_reg_data", reg_data, 32'h0);
    edge_step();
    rst = 1'b0;
    idle();
    wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h66; iss_vld = 1'b1; iss_rd = 5'd8;
    reg_sel = 5'd6;
    go();
    chk("post_rst_write", reg_data, 32'h66);
    chk("post_rst_issue", 32'(busy_cnt), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      if (rst) model_reset();
      wa_en      = 1'($urandom_range(0, 1));
      wa_addr    = 5'($urandom_range(0, 7));
      wa_data    = $urandom;
      wb_en      = 1'($urandom_range(0, 1));
      wb_addr    = 5'($urandom_range(0, 7));
      wb_raw     = $urandom;
      wb_mode    = 3'($urandom_range(0, 7));
      wb_memaddr = 2'($urandom_range(0, 3));
      iss_vld    = 1'($urandom_range(0, 1));
      iss_rd     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rd_addr    = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      reg_sel    = 5'($urandom_range(0, 9));
      go();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_sb_mp.md
Name: rf_sb_mp

Overview:
- Parametrised successor to the single-write register file for the pipelined MIPS core.
- Provides NRD combinational read ports and two synchronous write ports:
  - port A: ALU result.
  - port B: memory load, with built-in LW/LH/LHU/LB/LBU alignment and extension.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard (set at issue, cleared at writeback) that hazard logic uses for stall decisions.
- Register 0 reads as zero and is never busy.

Parameters:
- DATA_W, 32, register width; must be 32 for load extension.
- ADDR_W, 5, register index width; NREG = 2**ADDR_W.
- NRD, 2, number of read ports.
- BYPASS, 1, 1 = reads and busy see same-cycle writeback; 0 = registered view only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  read data.
- rd_busy  out  NRD  scoreboard busy bit per read address.
- wa_en  in  1  write port A enable.
- wa_addr  in  ADDR_W  write port A address.
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B (load) enable.
- wb_addr  in  ADDR_W  write port B address.
- wb_raw  in  DATA_W  raw memory word.
- wb_mode  in  3  load mode, RF_LW/LH/LHU/LB/LBU.
- wb_memaddr  in  2  byte offset of the load address.
- iss_vld  in  1  issue of an instruction with a destination register.
- iss_rd  in  ADDR_W  destination register of the issued instruction.
- busy_cnt  out  ADDR_W+1  number of busy registers.
- wr_coll  out  1  registered one-cycle pulse: both ports wrote the same non-zero address.
- ld_misalign  out  1  registered one-cycle pulse: misaligned LW/LH/LHU.
- reg_sel  in  ADDR_W  debug register select.
- reg_data  out  DATA_W  debug register data; 0 when reg_sel = 0.

Behaviour:
- Reset (async, rst=1):
  - Every register = 0; busy vector = 0; busy_cnt = 0; wr_coll = 0; ld_misalign = 0.
  - Reset takes effect immediately, including mid-operation. Issues and writes presented while rst=1 are dropped.
- Load extension (combinational, port B), result wb_ext:
  - LW: raw word.
  - LH: sign-extend halfword raw[16*memaddr[1] +: 16].
  - LHU: zero-extend the same halfword.
  - LB: sign-extend byte raw[8*memaddr +: 8].
  - LBU: zero-extend the same byte.
  - Any other code: behaves as LW.
- Misalignment:
  - ld_misalign is set for one cycle after a wb_en cycle with LW and memaddr≠0, or with LH/LHU and memaddr[0]=1.
  - LH/LHU still use memaddr[1]; bit 0 is ignored. The write still occurs.
- Writes (rising clk):
  - Address 0 is never written.
  - Both ports enabled with the same non-zero address: port A wins and wr_coll pulses one cycle later.
  - Otherwise both writes complete in the same cycle.
- Reads (combinational):
  - Address 0 returns 0.
  - With BYPASS=1, a read address matching an enabled non-zero write address returns the write data, port A having priority over wb_ext.
  - With BYPASS=0, reads return the stored value; new data is visible the cycle after the write.
- Scoreboard:
  - iss_vld with iss_rd≠0 sets busy[iss_rd] at the clock edge.
  - Any enabled write to address a clears busy[a].
  - Set and clear of the same address in the same cycle: set wins (new producer); busy stays 1.
  - Setting an already-busy register is legal (WAW): busy stays 1 and busy_cnt is unchanged.
  - Clearing a non-busy register is legal and has no effect.
  - rd_busy[i] = busy[addr_i]. With BYPASS=1 it is also masked by a same-cycle clear of that address. It is always 0 for address 0.
- busy_cnt:
  - Registered, equals the population count of the busy vector.
  - Updated incrementally: +1 per 0→1 transition, −1 per 1→0 transition. Net change per cycle lies in −2..+1.
  - Never wraps, because at most NREG−1 registers can be busy.
- Latency summary:
  - Write: 1 cycle to storage, 0 cycles through bypass.
  - Busy set: visible from the next cycle.
  - Pulses: 1 cycle after the triggering event.

Decomposition:
- Shared defs file ctrl_encode_def holds the load-mode codes:
  - RF_LW=3'b000, RF_LH=3'b001, RF_LHU=3'b010, RF_LB=3'b011, RF_LBU=3'b100.
  - Any other code is treated as LW.
- The load-mode codes are shared with the control unit and data-memory path.
- One natural sub-module, rf_load_ext: purely combinational, inputs raw/mode/memaddr, outputs ext data and misalign. It is reusable by the store-path and memory stage.
- The scoreboard and counter stay inline.

Test Plan:
- Reset, then write r5=0x12345678 on port A and read r5 on both ports:
  - BYPASS=1: data is 0x12345678 in the same cycle.
  - Following cycle: data is 0x12345678. r0 reads 0 after an attempted write of 0xFFFFFFFF.
- Load extension on port B, raw=0x80FF7F01:
  - LB off0: 0x00000001. LB off3: 0xFFFFFF80.
  - LBU off1: 0x0000007F. LH off2: 0xFFFF80FF. LHU off0: 0x00007F01.
  - LW off2: writes 0x80FF7F01 and ld_misalign pulses.
- Scoreboard: issue r7, then r9; busy_cnt=2 and rd_busy for r7=1.
  - Write r7 on port B: rd_busy for r7 is 0 in the same cycle with BYPASS=1; busy_cnt=1 next cycle.
  - Issue r3 with wa write to r3 in the same cycle: busy[r3] stays 1.
- Collision: wa and wb both write r4 (A=0x11, B raw=0x22, LW):
  - r4=0x11; wr_coll=1 for exactly one cycle.
  - Simultaneous wa r1 and wb r2 both complete.
- Assert rst mid-stream with 5 registers busy and pending writes:
  - All outputs are zero immediately, without waiting for a clock.
  - Writes and issues in the first cycle after rst deasserts behave normally.
